dcnt_timer: RTL and testbench

Loadable down-counting timer: the counterpart of the free-running up counter in the calculator datapath. It is loaded with a period, counts down on qualified `en` ticks, and reports expiry through a one-cycle `tc` pulse and a sticky `irq`/`ack` handshake. It runs in one-shot or periodic (auto-reload) mode, and it supports pause and resume, so the control FSM can time key debounce, display refresh and operation timeouts.

---
 rtl/dcnt_timer_if.sv | 25 ++
 rtl/dcnt_timer.sv | 98 +++++++++
 tb/tb_dcnt_timer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dcnt_timer_if.sv
// Command/status bundle for the loadable down-counting timer.
interface dcnt_timer_if #(parameter int unsigned N = 8);
    logic         en;
    logic         load;
    logic [N-1:0] din;
    logic         start;
    logic         stop;
    logic         mode;
    logic         ack;
    logic [N-1:0] q;
    logic         busy;
    logic         tc;
    logic         irq;
    logic         ovf;

    modport master (
        output en, load, din, start, stop, mode, ack,
        input  q, busy, tc, irq, ovf
    );

    modport slave (
        input  en, load, din, start, stop, mode, ack,
        output q, busy, tc, irq, ovf
    );
endinterface

// File: rtl/dcnt_timer.sv
// Loadable down-counting timer with one-shot/periodic modes, pause/resume,
// a one-cycle expiry pulse and a sticky irq/ack/ovf handshake.
module dcnt_timer #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    dcnt_timer_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

    localparam logic [N-1:0] ZERO = N'(0);
    localparam logic [N-1:0] ONE  = N'(1);

    state_e       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rl_q, rl_d;
    logic         busy_q, busy_d;
    logic         tc_q, tc_d;
    logic         irq_q, irq_d;
    logic         ovf_q, ovf_d;

    // State register; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= ZERO;
            rl_q    <= ZERO;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    // Command decode: load > stop > start > count.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        irq_d   = bus.ack ? 1'b0 : irq_q;

        if (bus.load) begin
            rl_d  = bus.din;
            q_d   = bus.din;
            ovf_d = 1'b0;
            if (bus.din == ZERO) begin
                state_d = S_IDLE;
            end
        end else if (bus.stop) begin
            if (state_q == S_RUN) begin
                state_d = S_HOLD;
            end
        end else if (bus.start && state_q != S_RUN) begin
            if (state_q == S_HOLD || q_q != ZERO) begin
                state_d = S_RUN;
            end else if (rl_q != ZERO) begin
                q_d     = rl_q;
                state_d = S_RUN;
            end
        end else if (state_q == S_RUN && bus.en && q_q != ZERO) begin
            if (q_q == ONE) begin
                // Expiry: a concurrent ack keeps irq set and does not flag ovf.
                tc_d  = 1'b1;
                irq_d = 1'b1;
                if (irq_q && !bus.ack) begin
                    ovf_d = 1'b1;
                end
                if (bus.mode) begin
                    q_d = rl_q;
                end else begin
                    q_d     = ZERO;
                    state_d = S_IDLE;
                end
            end else begin
                q_d = q_q - ONE;
            end
        end

        busy_d = (state_d == S_RUN);
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.tc   = tc_q;
    assign bus.irq  = irq_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_dcnt_timer.sv
// Directed-vector bench for dcnt_timer: a driver pushes the hand-computed
// post-edge outputs into a queue that a separate monitor checks.
module tb_dcnt_timer;
    logic clk;
    logic rst_n;

    dcnt_timer_if #(.N(8)) bus ();

    dcnt_timer #(.N(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       busy;
        logic       tc;
        logic       irq;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic vec(input logic r, input logic en, input logic ld, input logic [7:0] din,
                       input logic st, input logic sp, input logic md, input logic ak,
                       input logic [7:0] eq, input logic eb, input logic etc,
                       input logic eirq, input logic eovf);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        bus.en    = en;
        bus.load  = ld;
        bus.din   = din;
        bus.start = st;
        bus.stop  = sp;
        bus.mode  = md;
        bus.ack   = ak;
        @(posedge clk);
        e.id = vec_id; e.q = eq; e.busy = eb; e.tc = etc; e.irq = eirq; e.ovf = eovf;
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: outputs are registered, so every cycle presents a response.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (bus.q !== e.q || bus.busy !== e.busy || bus.tc !== e.tc ||
                bus.irq !== e.irq || bus.ovf !== e.ovf) begin
                bad++;
                $display("FAIL vec%0d: got q=%0d busy=%b tc=%b irq=%b ovf=%b, expected q=%0d busy=%b tc=%b irq=%b ovf=%b",
                         e.id, bus.q, bus.busy, bus.tc, bus.irq, bus.ovf,
                         e.q, e.busy, e.tc, e.irq, e.ovf);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.load = 1'b0; bus.din = 8'd0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.mode = 1'b0; bus.ack = 1'b0;

        //   rst en ld din  st sp md ak    q  b tc irq ovf
        // One-shot from 5
        vec(0, 1, 0, 8'd0, 0, 0, 0, 0,  8'd0, 0, 0, 0, 0);
        vec(1, 1, 1, 8'd5, 0, 0, 0, 0,  8'd5, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 0, 0,  8'd5, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd4, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd3, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd2, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd1, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd0, 0, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd0, 0, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 1,  8'd0, 0, 0, 0, 0);
        // Start from IDLE with q=0 reloads rl; then pause
        vec(1, 0, 0, 8'd0, 1, 0, 0, 0,  8'd5, 1, 0, 0, 0);
        vec(1, 0, 0, 8'd0, 0, 1, 0, 0,  8'd5, 0, 0, 0, 0);
        // Periodic rl=3, ack after first tc
        vec(1, 0, 1, 8'd3, 0, 0, 1, 0,  8'd3, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 1, 0,  8'd3, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd2, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd3, 1, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 1,  8'd2, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd3, 1, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd2, 1, 0, 1, 0);
        // Periodic rl=2 without ack: ovf on second tc; ack on third keeps irq
        vec(1, 1, 1, 8'd2, 0, 0, 1, 1,  8'd2, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd2, 1, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd2, 1, 1, 1, 1);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 1, 1);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 1,  8'd2, 1, 1, 1, 1);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 0, 1, 1);
        // Load 10 in RUN clears ovf and keeps running
        vec(1, 0, 1, 8'd10, 0, 0, 0, 0, 8'd10, 1, 0, 1, 0);
        // Pause at 7 for 4 cycles, resume, then stop+start together
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd9, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd8, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd7, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 1, 0, 0,  8'd7, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            vec(1, 1, 0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 0, 0,  8'd7, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd6, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd5, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 1, 1, 0, 0,  8'd5, 0, 0, 1, 0);
        // en gating from q=4: expiry after 8 cycles, irq already set -> ovf
        vec(1, 0, 0, 8'd0, 1, 0, 0, 0,  8'd5, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd4, 1, 0, 1, 0);
        vec(1, 0, 0, 8'd0, 0, 0, 0, 0,  8'd4, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd3, 1, 0, 1, 0);
        vec(1, 0, 0, 8'd0, 0, 0, 0, 0,  8'd3, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd2, 1, 0, 1, 0);
        vec(1, 0, 0, 8'd0, 0, 0, 0, 0,  8'd2, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd1, 1, 0, 1, 0);
        vec(1, 0, 0, 8'd0, 0, 0, 0, 0,  8'd1, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd0, 0, 1, 1, 1);
        vec(1, 0, 0, 8'd0, 0, 0, 0, 1,  8'd0, 0, 0, 0, 1);
        // load din=0 in RUN goes IDLE without tc; start with rl=0 ignored
        vec(1, 0, 1, 8'd6, 0, 0, 0, 0,  8'd6, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 0, 0,  8'd6, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd5, 1, 0, 0, 0);
        vec(1, 1, 1, 8'd0, 0, 0, 0, 0,  8'd0, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 0, 0,  8'd0, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd0, 0, 0, 0, 0);
        // rl=1 periodic: tc every cycle; ack coincident with expiry sets no ovf
        vec(1, 0, 1, 8'd1, 0, 0, 1, 0,  8'd1, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 1, 0,  8'd1, 1, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 1,  8'd1, 1, 1, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 1, 0,  8'd1, 1, 1, 1, 1);
        vec(1, 1, 0, 8'd0, 0, 1, 1, 0,  8'd1, 0, 0, 1, 1);
        // Load coincident with expiry wins, then reset mid-count at q=3
        vec(1, 0, 1, 8'd4, 0, 0, 0, 0,  8'd4, 0, 0, 1, 0);
        vec(1, 0, 0, 8'd0, 1, 0, 0, 0,  8'd4, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd3, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd2, 1, 0, 1, 0);
        vec(1, 1, 0, 8'd0, 0, 0, 0, 0,  8'd1, 1, 0, 1, 0);
        vec(1, 1, 1, 8'd3, 0, 0, 0, 0,  8'd3, 1, 0, 1, 0);
        vec(0, 1, 0, 8'd0, 1, 0, 0, 0,  8'd0, 0, 0, 0, 0);
        vec(1, 1, 0, 8'd0, 1, 0, 0, 0,  8'd0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d responses still pending, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
